// File: rtl/crc16_frame_checker.sv
//==============================================================================
// crc16_frame_checker
//
// Receive-side checker for frames of the form: payload bytes followed by a
// 2-byte CRC-16, high byte first. Removes the CRC and forwards the payload
// with valid/ready flow control. At end of frame it emits a one-cycle
// status pulse with the pass/fail verdict, both CRCs and the payload length.
//
// CRC: polynomial 0x1021, init 0x0000, MSB-first, no reflection, no final XOR.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   input byte handshake
//   in_data[7:0]        input byte
//   in_last             final byte of the frame (CRC low byte)
//   out_valid/out_ready payload byte handshake
//   out_data[7:0]       payload byte
//   out_last            final payload byte of the frame
//   status_valid        one-cycle end-of-frame pulse
//   crc_ok              computed CRC matches received CRC, frame not a runt
//   runt                frame shorter than 3 bytes
//   crc_calc[15:0]      CRC computed over the payload
//   crc_rx[15:0]        CRC received in the last two bytes of the frame
//   frame_len[15:0]     payload byte count, saturating at 0xFFFF
//
// Optional build macro CRC16_CHK_STATS_EN adds:
//   good_cnt[15:0]      saturating count of frames that passed
//   bad_cnt[15:0]       saturating count of frames that failed (runts included)
//==============================================================================
`timescale 1ns/1ps

module crc16_frame_checker (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        status_valid,
    output logic        crc_ok,
    output logic        runt,
    output logic [15:0] crc_calc,
    output logic [15:0] crc_rx,
    output logic [15:0] frame_len
`ifdef CRC16_CHK_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam logic [15:0] POLY = 16'h1021;

    // IDLE/ONE/STREAM encode how many bytes sit in the holding buffer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ONE    = 2'd1,
        STREAM = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  b0;          // older buffered byte
    logic [7:0]  b1;          // newer buffered byte
    logic [15:0] crc_acc;     // running CRC over bytes already forwarded
    logic [15:0] len_acc;     // running payload count for the current frame

    logic        accept;
    logic [15:0] crc_next;
    logic [15:0] len_next;
    logic [15:0] runt_rx;

    // One byte through the MSB-first CRC-16 shift register.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // In STREAM an accepted byte pushes b0 into the output register, so the
    // register must be empty or draining this cycle. IDLE/ONE only fill the
    // buffer and never block, even with a stale out_last byte still pending.
    always_comb begin
        case (state)
            IDLE, ONE: in_ready = 1'b1;
            STREAM:    in_ready = !out_valid || out_ready;
            default:   in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign crc_next = crc16_byte(crc_acc, b0);
    assign len_next = sat_inc16(len_acc);

    // A runt's "received CRC" is simply whatever bytes arrived.
    assign runt_rx  = (state == ONE) ? {b0, in_data} : {8'h00, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            b0           <= 8'h00;
            b1           <= 8'h00;
            crc_acc      <= 16'h0000;
            len_acc      <= 16'h0000;
            out_valid    <= 1'b0;
            out_data     <= 8'h00;
            out_last     <= 1'b0;
            status_valid <= 1'b0;
            crc_ok       <= 1'b0;
            runt         <= 1'b0;
            crc_calc     <= 16'h0000;
            crc_rx       <= 16'h0000;
            frame_len    <= 16'h0000;
`ifdef CRC16_CHK_STATS_EN
            good_cnt     <= 16'h0000;
            bad_cnt      <= 16'h0000;
`endif
        end else begin
            status_valid <= 1'b0;

            // Output slice drains on handshake; a load below overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                IDLE, ONE: begin
                    if (accept) begin
                        if (in_last) begin
                            // Too short to hold a CRC: report a runt, emit nothing.
                            runt         <= 1'b1;
                            crc_ok       <= 1'b0;
                            frame_len    <= 16'h0000;
                            crc_calc     <= 16'h0000;
                            crc_rx       <= runt_rx;
                            status_valid <= 1'b1;
                            state        <= REPORT;
                        end else if (state == IDLE) begin
                            b0    <= in_data;
                            state <= ONE;
                        end else begin
                            b1    <= in_data;
                            state <= STREAM;
                        end
                    end
                end

                STREAM: begin
                    if (accept) begin
                        // b0 is now known to be payload: forward it and fold it in.
                        out_data  <= b0;
                        out_valid <= 1'b1;
                        out_last  <= in_last;
                        crc_acc   <= crc_next;
                        len_acc   <= len_next;
                        if (in_last) begin
                            // b1 and this byte are the received CRC.
                            crc_calc     <= crc_next;
                            crc_rx       <= {b1, in_data};
                            crc_ok       <= (crc_next == {b1, in_data});
                            runt         <= 1'b0;
                            frame_len    <= len_next;
                            status_valid <= 1'b1;
                            state        <= REPORT;
                        end else begin
                            b0 <= b1;
                            b1 <= in_data;
                        end
                    end
                end

                REPORT: begin
                    crc_acc <= 16'h0000;
                    len_acc <= 16'h0000;
                    state   <= IDLE;
`ifdef CRC16_CHK_STATS_EN
                    if (crc_ok) begin
                        good_cnt <= sat_inc16(good_cnt);
                    end else begin
                        bad_cnt  <= sat_inc16(bad_cnt);
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_frame_checker.sv
`timescale 1ns/1ps

module tb_crc16_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        status_valid;
    logic        crc_ok;
    logic        runt;
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;
    logic [15:0] frame_len;
`ifdef CRC16_CHK_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
    int          mgood = 0;
    int          mbad  = 0;
`endif

    always #5 clk = ~clk;

    crc16_frame_checker dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .status_valid (status_valid),
        .crc_ok       (crc_ok),
        .runt         (runt),
        .crc_calc     (crc_calc),
        .crc_rx       (crc_rx),
        .frame_len    (frame_len)
`ifdef CRC16_CHK_STATS_EN
        ,
        .good_cnt     (good_cnt),
        .bad_cnt      (bad_cnt)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } out_t;

    typedef struct {
        logic        ok;
        logic        rnt;
        logic [15:0] calc;
        logic [15:0] rx;
        logic [15:0] len;
    } st_t;

    out_t       exp_out[$];
    st_t        exp_st[$];
    logic [7:0] frm[$];
    int         tests      = 0;
    int         fails      = 0;
    int         frame_pos  = 0;   // bytes of the current frame accepted so far
    bit         ignore_out = 1'b0;
    int         rdy_mode   = 0;   // 0: always ready, 1: toggle, 2: random
    out_t       mo;
    st_t        ms;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // CRC as the remainder of (message * x^16) divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
        int unsigned rem;
        logic [7:0]  aug[$];
        rem = 0;
        aug = msg;
        aug.push_back(8'h00);
        aug.push_back(8'h00);
        foreach (aug[i]) begin
            for (int b = 7; b >= 0; b--) begin
                rem = (rem << 1) | 32'(aug[i][b]);
                if ((rem & 32'h10000) != 0) rem = rem ^ 32'h11021;
            end
        end
        return rem[15:0];
    endfunction

    // Push the expected payload and status for the frame in frm.
    task automatic expect_frame();
        st_t        s;
        out_t       o;
        logic [7:0] pl[$];
        int         n;
        n = frm.size();
        if (n < 3) begin
            s.ok   = 1'b0;
            s.rnt  = 1'b1;
            s.calc = 16'h0000;
            s.len  = 16'h0000;
            s.rx   = (n == 1) ? {8'h00, frm[0]} : {frm[0], frm[1]};
        end else begin
            for (int i = 0; i < n - 2; i++) begin
                pl.push_back(frm[i]);
                o.data = frm[i];
                o.last = (i == n - 3);
                exp_out.push_back(o);
            end
            s.calc = ref_crc(pl);
            s.rx   = {frm[n-2], frm[n-1]};
            s.ok   = (s.calc == s.rx);
            s.rnt  = 1'b0;
            s.len  = 16'(n - 2);
        end
        exp_st.push_back(s);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 1000) begin
                fails++;
                tests++;
                $display("FAIL send_timeout: in_ready stayed 0, required 1");
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $fatal(1, "in_ready timeout");
            end
        end
        @(posedge clk);
        #1;
        if (l) frame_pos = 0;
        else   frame_pos++;
    endtask

    task automatic send_frame(input bit gaps, input bit chk_gap);
        int w;
        expect_frame();
        foreach (frm[i]) begin
            send_byte(frm[i], (i == frm.size() - 1), w);
            if (chk_gap && i == 0) chk("b2b_ready_gap_cycles", w, 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic build_good(input int npl);
        logic [15:0] c;
        frm.delete();
        for (int i = 0; i < npl; i++) frm.push_back(8'($urandom_range(0, 255)));
        c = ref_crc(frm);
        frm.push_back(c[15:8]);
        frm.push_back(c[7:0]);
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((exp_out.size() != 0 || exp_st.size() != 0) && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("drain_pending_items", exp_out.size() + exp_st.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready && !ignore_out) begin
                if (exp_out.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got byte 0x%0h, required no output", out_data);
                end else begin
                    mo = exp_out.pop_front();
                    chk("out_data", out_data, mo.data);
                    chk("out_last", out_last, mo.last);
                end
            end
            if (status_valid) begin
                if (exp_st.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL status_unexpected: got status_valid 1, required 0");
                end else begin
                    ms = exp_st.pop_front();
                    chk("crc_ok",    crc_ok,    ms.ok);
                    chk("runt",      runt,      ms.rnt);
                    chk("crc_calc",  crc_calc,  ms.calc);
                    chk("crc_rx",    crc_rx,    ms.rx);
                    chk("frame_len", frame_len, ms.len);
`ifdef CRC16_CHK_STATS_EN
                    if (ms.ok) mgood++;
                    else       mbad++;
`endif
                end
            end
            // Two or more bytes of a frame accepted means the buffer is full.
            if (!ignore_out && frame_pos >= 2 && out_valid && !out_ready)
                chk("stream_backpressure_in_ready", in_ready, 0);
        end
    end

    // Watchdog
    initial begin
        #500000;
        fails++;
        tests++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int w;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",     in_ready,     1);
        chk("rst_out_valid",    out_valid,    0);
        chk("rst_out_data",     out_data,     0);
        chk("rst_out_last",     out_last,     0);
        chk("rst_status_valid", status_valid, 0);
        chk("rst_crc_ok",       crc_ok,       0);
        chk("rst_runt",         runt,         0);
        chk("rst_crc_calc",     crc_calc,     0);
        chk("rst_crc_rx",       crc_rx,       0);
        chk("rst_frame_len",    frame_len,    0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed: good frame, bad CRC, runts, minimum payload
        rdy_mode = 0;
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
        send_frame(1'b0, 1'b0);
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC4};
        send_frame(1'b0, 1'b0);
        frm = '{8'hAA};
        send_frame(1'b0, 1'b0);
        frm = '{8'hAA, 8'hBB};
        send_frame(1'b0, 1'b0);
        build_good(1);
        send_frame(1'b0, 1'b0);
        in_valid = 1'b0;
        wait_drain();

        // Toggling out_ready
        rdy_mode = 1;
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
        send_frame(1'b0, 1'b0);
        in_valid = 1'b0;
        wait_drain();

        // Back-to-back frames with in_valid held high
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        build_good(9);
        send_frame(1'b0, 1'b0);
        build_good(6);
        send_frame(1'b0, 1'b1);
        in_valid = 1'b0;
        wait_drain();

        // Randomized frames with random backpressure and gaps
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                frm.delete();
                repeat ($urandom_range(1, 2)) frm.push_back(8'($urandom_range(0, 255)));
            end else if (kind <= 2) begin
                frm.delete();
                repeat ($urandom_range(3, 20)) frm.push_back(8'($urandom_range(0, 255)));
            end else begin
                build_good($urandom_range(1, 18));
            end
            send_frame(1'b1, 1'b0);
        end
        in_valid = 1'b0;
        wait_drain();

        // Reset part-way through a frame, then a clean frame
        rdy_mode   = 0;
        ignore_out = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b0, w);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_out_valid",    out_valid,    0);
        chk("midrst_status_valid", status_valid, 0);
        chk("midrst_in_ready",     in_ready,     1);
        chk("midrst_frame_len",    frame_len,    0);
        rst        = 1'b0;
        frame_pos  = 0;
`ifdef CRC16_CHK_STATS_EN
        mgood = 0;
        mbad  = 0;
`endif
        @(posedge clk);
        #1;
        ignore_out = 1'b0;
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
        send_frame(1'b0, 1'b0);
        in_valid = 1'b0;
        wait_drain();

`ifdef CRC16_CHK_STATS_EN
        chk("good_cnt", good_cnt, 32'(mgood));
        chk("bad_cnt",  bad_cnt,  32'(mbad));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc16_frame_checker.md
# crc16_frame_checker

Receive-side companion to the byte-parallel CRC-16 generator. It accepts framed bytes, each frame being payload followed by a 2-byte CRC, MSB first. It strips the CRC and forwards the payload with valid/ready flow control. At end of frame it reports a one-cycle status pulse carrying the pass/fail result, the computed and received CRCs, and the payload length.

## Interface
Parameters: none. CRC is fixed to polynomial 0x1021, init 0x0000, MSB-first, no reflection, no final XOR.

Ports:
- `clk`  in  1  — single clock; all logic rising-edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — input byte valid.
- `in_ready`  out  1  — checker can accept a byte.
- `in_data`  in  8  — input byte.
- `in_last`  in  1  — marks the final byte of the frame (the CRC low byte).
- `out_valid`  out  1  — payload byte valid.
- `out_ready`  in  1  — downstream accepts the payload byte.
- `out_data`  out  8  — payload byte.
- `out_last`  out  1  — marks the final payload byte.
- `status_valid`  out  1  — one-cycle end-of-frame pulse.
- `crc_ok`  out  1  — computed CRC equals received CRC and the frame is not a runt.
- `runt`  out  1  — frame shorter than 3 bytes.
- `crc_calc`  out  16  — CRC over payload bytes.
- `crc_rx`  out  16  — received CRC, `{byte n-2, byte n-1}`.
- `frame_len`  out  16  — payload byte count, saturating at 0xFFFF.

## Operation
- A byte is accepted when `in_valid && in_ready`.
- A 2-entry holding buffer delays bytes. Entries: `b0` is older, `b1` is newer.
- FSM states:
  - IDLE: 0 bytes buffered. Accept → ONE.
  - ONE: 1 byte buffered. Accept non-last → STREAM.
  - STREAM: 2 bytes buffered. Accept non-last: `b0` moves to the output register, `crc` is updated with `b0`, and the buffer shifts.
  - REPORT: lasts one cycle, then → IDLE.
- Last byte accepted in STREAM:
  - `b0` moves to output with `out_last=1` and `crc` is updated with `b0`.
  - `crc_rx` = `{b1, in_data}`.
  - `crc_calc` = the updated CRC.
  - `crc_ok` = (`crc_calc == crc_rx`).
  - → REPORT.
- Last byte accepted in IDLE or ONE (runt):
  - No payload is emitted.
  - `runt=1`, `crc_ok=0`, `frame_len=0`, `crc_rx` = bytes received (zero-extended to 16 bits), `crc_calc=0`.
  - → REPORT.
- CRC register:
  - Cleared to 0x0000 on entry to IDLE.
  - Per-byte update is the standard 8-step MSB-first shift/XOR with 0x1021.
  - Computed combinationally within one cycle.
- `frame_len` increments for every byte moved from `b0` to the output register, saturates at 0xFFFF, and clears on entry to IDLE.
- Status outputs hold their value until the next REPORT. Only `status_valid` pulses.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_data=0`, `out_last=0`.
  - `status_valid=0`, `crc_ok=0`, `runt=0`.
  - `crc_calc=0`, `crc_rx=0`, `frame_len=0`.
  - FSM in IDLE, buffer empty.
- `in_ready` by state:
  - IDLE and ONE: 1.
  - STREAM: `!out_valid || out_ready`.
  - REPORT: 0.
- Payload byte k appears on `out_data` the cycle after byte k+2 is accepted. The output register is a registered slice.
- `out_valid` falls after an `out_ready` handshake unless a new byte is loaded in the same cycle. Simultaneous drain and load is allowed and keeps `out_valid=1`.
- `status_valid` is high the cycle after the last byte is accepted, coinciding with REPORT.
- A pending `out_last` byte may still be waiting in the output register during REPORT and the following IDLE/ONE states. The next frame fills the buffer without blocking until it reaches STREAM.
- Throughput: 1 byte/cycle sustained within a frame, plus one REPORT bubble per frame.
- Reset mid-frame: buffer, output register, CRC and FSM are cleared immediately. No status is generated.

## Configuration
- `CRC16_CHK_STATS_EN` defined:
  - Adds outputs `good_cnt[15:0]` and `bad_cnt[15:0]`, both resetting to 0.
  - In REPORT, `good_cnt` increments if `crc_ok`, otherwise `bad_cnt` increments (runts count as bad).
  - Both counters saturate at 0xFFFF.
- `CRC16_CHK_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Frame 31 32 33 34 35 36 37 38 39 31 C3, `out_ready=1` → out 31..39 with `out_last` on 39; `status_valid` pulse with `crc_ok=1`, `crc_calc=0x31C3`, `crc_rx=0x31C3`, `frame_len=9`.
- Same frame with the final byte C4 → identical payload out; `crc_ok=0`, `crc_calc=0x31C3`, `crc_rx=0x31C4`.
- Frames of length 1 (AA) and 2 (AA BB) → no `out_valid`; `runt=1`, `crc_ok=0`, `frame_len=0`, `crc_rx=0x00AA` and `0xAABB` respectively.
- Frame of 9 payload bytes + CRC with `out_ready` toggling 1010… → no byte lost or duplicated; `in_ready=0` whenever STREAM has `out_valid=1` and `out_ready=0`; status identical to the first scenario.
- Back-to-back valid frames with `in_valid` held high → exactly one `in_ready=0` cycle between frames; two status pulses; with `CRC16_CHK_STATS_EN`, `good_cnt=2`.
- Assert `rst` after 5 bytes of a frame, then send a full good frame → no status for the aborted frame; the good frame passes with `frame_len=9`.
